// File: rtl/mac_dot_ctrl_if.sv
// Command / operand / result handshake bundle for mac_dot_ctrl.
// Carries the cmd_acc field only when MAC_DOT_CTRL_ACCUM_EN is defined.
interface mac_dot_ctrl_if #(
  parameter int DW        = 32,
  parameter int LEN_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LEN_WIDTH-1:0] cmd_len;
  logic [2:0]           cmd_rnd;
`ifdef MAC_DOT_CTRL_ACCUM_EN
  logic                 cmd_acc;
`endif
  logic                 op_valid;
  logic                 op_ready;
  logic [DW-1:0]        op_a;
  logic [DW-1:0]        op_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [DW-1:0]        res_data;
  logic [7:0]           res_status;

  // Issue logic side
  modport master (
`ifdef MAC_DOT_CTRL_ACCUM_EN
    output cmd_acc,
`endif
    output cmd_valid, cmd_len, cmd_rnd,
    input  cmd_ready,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  res_valid, res_data, res_status,
    output res_ready
  );

  // Sequencer side
  modport slave (
`ifdef MAC_DOT_CTRL_ACCUM_EN
    input  cmd_acc,
`endif
    input  cmd_valid, cmd_len, cmd_rnd,
    output cmd_ready,
    input  op_valid, op_a, op_b,
    output op_ready,
    output res_valid, res_data, res_status,
    input  res_ready
  );
endinterface

// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer driving one registered floating-point MAC unit.
// Optional MAC_DOT_CTRL_ACCUM_EN: cmd_acc skips the accumulator clear to chain partial sums.
module mac_dot_ctrl #(
  parameter  int SIG_WIDTH = 23,
  parameter  int EXP_WIDTH = 8,
  parameter  int LEN_WIDTH = 8,
  localparam int DW        = SIG_WIDTH + EXP_WIDTH + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mac_dot_ctrl_if.slave bus,
  output logic          mac_en,
  output logic          mac_clr_n,
  output logic [DW-1:0] mac_a,
  output logic [DW-1:0] mac_b,
  output logic [2:0]    mac_rnd,
  input  logic [DW-1:0] mac_data_out,
  input  logic [7:0]    mac_status
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ACC   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [LEN_WIDTH-1:0] CNT_ZERO = LEN_WIDTH'(0);
  localparam logic [LEN_WIDTH-1:0] CNT_ONE  = LEN_WIDTH'(1);

  logic [2:0]           state_r;
  logic [2:0]           state_s;
  logic [LEN_WIDTH-1:0] cnt_r;
  logic [2:0]           rnd_r;
  logic [7:0]           status_acc_r;
  logic                 en_d_r;
  logic                 cmd_fire_s;
  logic                 op_fire_s;
  logic                 skip_clr_s;

`ifdef MAC_DOT_CTRL_ACCUM_EN
  assign skip_clr_s = bus.cmd_acc;
`else
  assign skip_clr_s = 1'b0;
`endif

  assign cmd_fire_s = (state_r == ST_IDLE) && bus.cmd_valid;
  assign op_fire_s  = (state_r == ST_ACC) && bus.op_valid;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!bus.cmd_valid) begin
          state_s = ST_IDLE;
        end else if (!skip_clr_s) begin
          state_s = ST_CLEAR;
        end else if (bus.cmd_len == CNT_ZERO) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_ACC: begin
        // A beat arriving with count already 0 cannot occur; leave ACC rather than wrap
        if (bus.op_valid && (cnt_r <= CNT_ONE)) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_FLUSH: begin
        state_s = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Remaining-pair count and latched rounding mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
      rnd_r <= 3'd0;
    end else if (cmd_fire_s) begin
      cnt_r <= bus.cmd_len;
      rnd_r <= bus.cmd_rnd;
    end else if (op_fire_s && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
      rnd_r <= rnd_r;
    end else begin
      cnt_r <= cnt_r;
      rnd_r <= rnd_r;
    end
  end

  // MAC status is only meaningful the cycle after an enabled step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d_r       <= 1'b0;
      status_acc_r <= 8'd0;
    end else begin
      en_d_r <= mac_en;
      if (cmd_fire_s) begin
        status_acc_r <= 8'd0;
      end else if (en_d_r) begin
        status_acc_r <= status_acc_r | mac_status;
      end else begin
        status_acc_r <= status_acc_r;
      end
    end
  end

  // Handshake and MAC control decode from the state register
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.op_ready  = 1'b0;
    bus.res_valid = 1'b0;
    mac_en        = 1'b0;
    mac_clr_n     = 1'b1;
    case (state_r)
      ST_IDLE:  bus.cmd_ready = 1'b1;
      ST_CLEAR: mac_clr_n     = 1'b0;
      ST_ACC: begin
        bus.op_ready = 1'b1;
        mac_en       = bus.op_valid;
      end
      ST_FLUSH: mac_en        = 1'b0;
      ST_DONE:  bus.res_valid = 1'b1;
      default:  bus.cmd_ready = 1'b0;
    endcase
  end

  assign bus.res_data   = (state_r == ST_DONE) ? mac_data_out : {DW{1'b0}};
  assign bus.res_status = status_acc_r;
  assign mac_a          = bus.op_a;
  assign mac_b          = bus.op_b;
  assign mac_rnd        = rnd_r;

endmodule
